md5_padder: RTL

MD5_PADDER -- requirements
Module: md5_padder

---
 rtl/md5_padder_if.sv | 49 ++++
 rtl/md5_padder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/md5_padder_if.sv
// ---------------------------------------------------------------------------
// md5_padder_if
// Purpose : groups the byte-stream input and the 512-bit block output of the
//           MD5 padder into one bundle.
// Signals :
//   in_valid  - message byte present
//   in_ready  - padder accepts a byte this cycle
//   in_data   - message byte, moves when in_valid && in_ready
//   in_last   - transferred byte is the final byte of the message
//   blk_valid - 512-bit block available
//   blk_ready - round engine takes the block this cycle
//   blk_data  - block, message byte i of the block at bits [8i+7:8i]
//   blk_last  - block is the final block of the message
// Modports:
//   master - environment side: drives the byte stream, consumes blocks
//   slave  - padder side: accepts bytes, produces blocks
// ---------------------------------------------------------------------------
interface md5_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output blk_ready,
    input  in_ready,
    input  blk_valid,
    input  blk_data,
    input  blk_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  blk_ready,
    output in_ready,
    output blk_valid,
    output blk_data,
    output blk_last
  );
endinterface

// File: rtl/md5_padder.sv
// ---------------------------------------------------------------------------
// md5_padder
// Purpose : collects a byte stream into 512-bit MD5 blocks and appends the
//           MD5 padding (0x80, zero fill, 64-bit little-endian bit length).
//           A message whose tail does not leave room for the length field
//           produces one extra padding-only block.
// Ports   :
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - md5_padder_if.slave (byte stream in, block stream out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// FILL    | accepting message bytes into the block buffer
// OUT     | presenting a block built from message bytes (plus padding)
// OUT_PAD | presenting the extra block that carries only padding/length
// ---------------------------------------------------------------------------
module md5_padder (
  input  logic          clk,
  input  logic          rst,
  md5_padder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_OUT     = 2'd1,
    S_OUT_PAD = 2'd2
  } state_t;

  state_t       r_state;
  logic [5:0]   r_idx;
  logic [60:0]  r_len;
  logic         r_pend_len;
  logic         r_pend_80;
  logic [511:0] r_buf;
  logic         r_blk_last;
  logic         r_in_ready;
  logic         r_blk_valid;

  logic         w_xfer;
  logic         w_hs;
  logic [5:0]   w_idx_inc;
  logic [60:0]  w_len_inc;
  logic [511:0] w_pad_blk;

  assign w_xfer    = bus.in_valid && r_in_ready;
  assign w_hs      = r_blk_valid && bus.blk_ready;
  assign w_idx_inc = r_idx + 6'd1;
  assign w_len_inc = r_len + 61'd1;

  // Padding-only block: optional 0x80 at byte 0 (when the message filled the
  // previous block exactly) and the bit length in bytes 56..63.
  assign w_pad_blk = {r_len, 3'b000, 440'd0, (r_pend_80 ? 8'h80 : 8'h00)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_idx       <= 6'd0;
      r_len       <= 61'd0;
      r_pend_len  <= 1'b0;
      r_pend_80   <= 1'b0;
      r_buf       <= '0;
      r_blk_last  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_blk_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            r_buf[{r_idx, 3'b000} +: 8] <= bus.in_data;
            r_idx <= w_idx_inc;
            r_len <= w_len_inc;
            if (bus.in_last) begin
              // 0x80 goes right after the final byte unless that byte closed
              // the block; then it opens the padding block instead.
              if (r_idx != 6'd63) begin
                r_buf[{w_idx_inc, 3'b000} +: 8] <= 8'h80;
              end
              if (r_idx <= 6'd54) begin
                r_buf[511:448] <= {w_len_inc, 3'b000};
                r_blk_last     <= 1'b1;
              end else begin
                r_blk_last <= 1'b0;
                r_pend_len <= 1'b1;
                r_pend_80  <= (r_idx == 6'd63);
              end
              r_state     <= S_OUT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
            end else if (r_idx == 6'd63) begin
              r_blk_last  <= 1'b0;
              r_state     <= S_OUT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
            end
          end
        end

        S_OUT: begin
          if (w_hs) begin
            if (r_pend_len) begin
              r_buf      <= w_pad_blk;
              r_blk_last <= 1'b1;
              r_state    <= S_OUT_PAD;
            end else begin
              r_buf       <= '0;
              r_idx       <= 6'd0;
              // The running length must survive the intermediate blocks of a
              // long message; it restarts only once the message is finished.
              if (r_blk_last) begin
                r_len <= 61'd0;
              end
              r_blk_last  <= 1'b0;
              r_state     <= S_FILL;
              r_in_ready  <= 1'b1;
              r_blk_valid <= 1'b0;
            end
          end
        end

        S_OUT_PAD: begin
          if (w_hs) begin
            r_buf       <= '0;
            r_idx       <= 6'd0;
            r_len       <= 61'd0;
            r_pend_len  <= 1'b0;
            r_pend_80   <= 1'b0;
            r_blk_last  <= 1'b0;
            r_state     <= S_FILL;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_FILL;
          r_in_ready  <= 1'b1;
          r_blk_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.blk_valid = r_blk_valid;
  assign bus.blk_data  = r_buf;
  assign bus.blk_last  = r_blk_last;

endmodule
